// File: rtl/mem_access_ctrl.sv
//-----------------------------------------------------------------------------
// Module   : mem_access_ctrl
// Purpose  : Sequencer that arbitrates one memory access at a time between
//            the datapath (cpu) and a special port (loader/IO). It drives the
//            MAR/MDR load strobes, the MDR source select and the memory write
//            enable. Reads use a fixed MEM_LAT-cycle wait.
// Ports    :
//   clk         in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   cpu_req     in   datapath access request
//   cpu_we      in   datapath write (1) / read (0)
//   spc_req     in   special-port access request
//   spc_we      in   special-port write (1) / read (0)
//   cpu_ack     out  one-cycle datapath completion pulse
//   spc_ack     out  one-cycle special-port completion pulse
//   ldMAR       out  MAR load enable
//   ldMARSpcIn  out  MAR input select: special address (1) / Bus (0)
//   ldMDR       out  MDR load enable
//   selMDR      out  MDR source: 00 Bus, 01 memOut, 11 special data
//   memWE       out  memory write enable
//   busy        out  high whenever the sequencer is not idle
//   grant       out  current owner: 0 datapath, 1 special port
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl #(
  parameter int MEM_LAT = 1  // cycles from MAR load to valid memOut, 1..7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic       spc_req,
  input  logic       spc_we,
  output logic       cpu_ack,
  output logic       spc_ack,
  output logic       ldMAR,
  output logic       ldMARSpcIn,
  output logic       ldMDR,
  output logic [1:0] selMDR,
  output logic       memWE,
  output logic       busy,
  output logic       grant
);

  localparam logic [2:0] C_LAT = 3'(MEM_LAT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAR  = 3'd1,
    S_WAIT = 3'd2,
    S_RD   = 3'd3,
    S_WMDR = 3'd4,
    S_WR   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t     state_q;
  logic       owner_q;
  logic       we_q;
  logic       last_grant_q;
  logic [2:0] cnt_q;

  logic       cpu_ack_q;
  logic       spc_ack_q;
  logic       ldMAR_q;
  logic       ldMARSpcIn_q;
  logic       ldMDR_q;
  logic [1:0] selMDR_q;
  logic       memWE_q;
  logic       busy_q;
  logic       grant_q;

  // Owner picked in IDLE: a lone requester wins; on a tie the requester that
  // did not win last time gets the grant.
  logic owner_d;
  logic we_d;

  always_comb begin
    owner_d = spc_req;
    if (cpu_req && spc_req) begin
      owner_d = ~last_grant_q;
    end
    we_d = owner_d ? spc_we : cpu_we;
  end

  // Outputs are registered: each branch sets the strobes that belong to the
  // state being entered, so they are valid throughout that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 3'd0;
      cpu_ack_q    <= 1'b0;
      spc_ack_q    <= 1'b0;
      ldMAR_q      <= 1'b0;
      ldMARSpcIn_q <= 1'b0;
      ldMDR_q      <= 1'b0;
      selMDR_q     <= 2'b00;
      memWE_q      <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
    end else begin
      cpu_ack_q    <= 1'b0;
      spc_ack_q    <= 1'b0;
      ldMAR_q      <= 1'b0;
      ldMARSpcIn_q <= 1'b0;
      ldMDR_q      <= 1'b0;
      selMDR_q     <= 2'b00;
      memWE_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cpu_req || spc_req) begin
            state_q      <= S_MAR;
            owner_q      <= owner_d;
            we_q         <= we_d;
            cnt_q        <= C_LAT;
            ldMAR_q      <= 1'b1;
            ldMARSpcIn_q <= owner_d;
            busy_q       <= 1'b1;
            grant_q      <= owner_d;
          end
        end

        S_MAR: begin
          if (we_q) begin
            state_q  <= S_WMDR;
            ldMDR_q  <= 1'b1;
            selMDR_q <= owner_q ? 2'b11 : 2'b00;
          end else begin
            state_q <= S_WAIT;
          end
        end

        // cnt_q enters WAIT holding MEM_LAT, so leaving on 1 gives exactly
        // MEM_LAT cycles in this state.
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q  <= S_RD;
            ldMDR_q  <= 1'b1;
            selMDR_q <= 2'b01;
          end
        end

        S_RD: begin
          state_q   <= S_DONE;
          cpu_ack_q <= ~owner_q;
          spc_ack_q <= owner_q;
        end

        S_WMDR: begin
          state_q <= S_WR;
          memWE_q <= we_q;
        end

        S_WR: begin
          state_q   <= S_DONE;
          cpu_ack_q <= ~owner_q;
          spc_ack_q <= owner_q;
        end

        // Always return to IDLE so requests are re-arbitrated there.
        S_DONE: begin
          state_q      <= S_IDLE;
          last_grant_q <= owner_q;
          busy_q       <= 1'b0;
          grant_q      <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          grant_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign spc_ack    = spc_ack_q;
  assign ldMAR      = ldMAR_q;
  assign ldMARSpcIn = ldMARSpcIn_q;
  assign ldMDR      = ldMDR_q;
  assign selMDR     = selMDR_q;
  assign memWE      = memWE_q;
  assign busy       = busy_q;
  assign grant      = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//-----------------------------------------------------------------------------
// Module   : tb_mem_access_ctrl
// Purpose  : Directed bench for mem_access_ctrl. Two instances share the
//            stimulus: one with MEM_LAT=1 and one with MEM_LAT=3. Outputs are
//            packed as {busy, grant, cpu_ack, spc_ack, ldMAR, ldMARSpcIn,
//            ldMDR, selMDR[1:0], memWE} and compared cycle by cycle against
//            hand-computed vectors, 1 time unit after each rising edge.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_req = 1'b0;
  logic cpu_we = 1'b0;
  logic spc_req = 1'b0;
  logic spc_we = 1'b0;

  logic       a_cpu_ack, a_spc_ack, a_ldMAR, a_ldMARSpcIn, a_ldMDR, a_memWE;
  logic       a_busy, a_grant;
  logic [1:0] a_selMDR;
  logic       b_cpu_ack, b_spc_ack, b_ldMAR, b_ldMARSpcIn, b_ldMDR, b_memWE;
  logic       b_busy, b_grant;
  logic [1:0] b_selMDR;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .spc_req(spc_req), .spc_we(spc_we),
    .cpu_ack(a_cpu_ack), .spc_ack(a_spc_ack),
    .ldMAR(a_ldMAR), .ldMARSpcIn(a_ldMARSpcIn), .ldMDR(a_ldMDR),
    .selMDR(a_selMDR), .memWE(a_memWE), .busy(a_busy), .grant(a_grant)
  );

  mem_access_ctrl #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .spc_req(spc_req), .spc_we(spc_we),
    .cpu_ack(b_cpu_ack), .spc_ack(b_spc_ack),
    .ldMAR(b_ldMAR), .ldMARSpcIn(b_ldMARSpcIn), .ldMDR(b_ldMDR),
    .selMDR(b_selMDR), .memWE(b_memWE), .busy(b_busy), .grant(b_grant)
  );

  logic [9:0] v1, v3;
  assign v1 = {a_busy, a_grant, a_cpu_ack, a_spc_ack, a_ldMAR, a_ldMARSpcIn,
               a_ldMDR, a_selMDR, a_memWE};
  assign v3 = {b_busy, b_grant, b_cpu_ack, b_spc_ack, b_ldMAR, b_ldMARSpcIn,
               b_ldMDR, b_selMDR, b_memWE};

  // Vector shorthands
  localparam logic [9:0] IDL  = 10'b0000000000;
  localparam logic [9:0] CMAR = 10'b1000100000; // cpu owner, MAR
  localparam logic [9:0] CWT  = 10'b1000000000; // cpu owner, WAIT
  localparam logic [9:0] CRD  = 10'b1000001010; // cpu owner, RD
  localparam logic [9:0] CWM  = 10'b1000001000; // cpu owner, WMDR (Bus)
  localparam logic [9:0] CWR  = 10'b1000000001; // cpu owner, WR
  localparam logic [9:0] CDN  = 10'b1010000000; // cpu owner, DONE
  localparam logic [9:0] SMAR = 10'b1100110000; // spc owner, MAR
  localparam logic [9:0] SWM  = 10'b1100001110; // spc owner, WMDR (special)
  localparam logic [9:0] SWR  = 10'b1100000001; // spc owner, WR
  localparam logic [9:0] SDN  = 10'b1101000000; // spc owner, DONE

  task automatic chk(input string tag, input logic [9:0] obs,
                     input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [9:0] exp, input bit lat3);
    @(posedge clk);
    #1;
    chk(tag, lat3 ? v3 : v1, exp);
  endtask

  task automatic do_reset();
    cpu_req = 1'b0; spc_req = 1'b0; cpu_we = 1'b0; spc_we = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state, both instances
    cpu_req = 1'b1; spc_req = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_l1", v1, IDL);
    chk("reset_l3", v3, IDL);
    reset = 1'b0; cpu_req = 1'b0; spc_req = 1'b0;

    // Single datapath read, MEM_LAT=1
    cpu_req = 1'b1; cpu_we = 1'b0;
    step("rd_c1", CMAR, 0);
    cpu_req = 1'b0;
    step("rd_c2", CWT, 0);
    step("rd_c3", CRD, 0);
    step("rd_c4", CDN, 0);
    step("rd_c5", IDL, 0);
    step("rd_c6", IDL, 0);

    // Special-port write
    spc_req = 1'b1; spc_we = 1'b1;
    step("sw_c1", SMAR, 0);
    spc_req = 1'b0; spc_we = 1'b0;
    step("sw_c2", SWM, 0);
    step("sw_c3", SWR, 0);
    step("sw_c4", SDN, 0);
    step("sw_c5", IDL, 0);

    // Simultaneous held requests after reset: cpu, spc, cpu
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; spc_req = 1'b1; spc_we = 1'b1;
    step("tie_c1", CMAR, 0);
    step("tie_c2", CWT, 0);
    step("tie_c3", CRD, 0);
    step("tie_c4", CDN, 0);
    step("tie_c5", IDL, 0);
    step("tie_c6", SMAR, 0);
    step("tie_c7", SWM, 0);
    step("tie_c8", SWR, 0);
    step("tie_c9", SDN, 0);
    step("tie_c10", IDL, 0);
    step("tie_c11", CMAR, 0);
    cpu_req = 1'b0; spc_req = 1'b0;
    step("tie_c12", CWT, 0);
    step("tie_c13", CRD, 0);
    step("tie_c14", CDN, 0);
    step("tie_c15", IDL, 0);

    // MEM_LAT=3 read on the second instance
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0;
    step("l3_c1", CMAR, 1);
    cpu_req = 1'b0;
    step("l3_c2", CWT, 1);
    step("l3_c3", CWT, 1);
    step("l3_c4", CWT, 1);
    step("l3_c5", CRD, 1);
    step("l3_c6", CDN, 1);
    step("l3_c7", IDL, 1);

    // Reset during WMDR abandons the write
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1;
    step("ab_c1", CMAR, 0);
    cpu_req = 1'b0;
    step("ab_c2", CWM, 0);
    reset = 1'b1;
    step("ab_c3", IDL, 0);
    reset = 1'b0;
    step("ab_c4", IDL, 0);
    step("ab_c5", IDL, 0);
    // last_grant back to 1: a tie must go to the datapath
    cpu_req = 1'b1; cpu_we = 1'b1; spc_req = 1'b1; spc_we = 1'b0;
    step("ab_tie", CMAR, 0);
    cpu_req = 1'b0; spc_req = 1'b0;
    step("ab_wm", CWM, 0);
    step("ab_wr", CWR, 0);
    step("ab_dn", CDN, 0);
    step("ab_idl", IDL, 0);

    // cpu_req dropped at cycle 2 of a write; we flip mid-flight is ignored
    cpu_req = 1'b1; cpu_we = 1'b1;
    step("dr_c1", CMAR, 0);
    cpu_we = 1'b0;
    step("dr_c2", CWM, 0);
    cpu_req = 1'b0;
    step("dr_c3", CWR, 0);
    step("dr_c4", CDN, 0);
    step("dr_c5", IDL, 0);
    step("dr_c6", IDL, 0);

    // Held request after ack becomes a new request
    cpu_req = 1'b1; cpu_we = 1'b0;
    step("hd_c1", CMAR, 0);
    step("hd_c2", CWT, 0);
    step("hd_c3", CRD, 0);
    step("hd_c4", CDN, 0);
    step("hd_c5", IDL, 0);
    step("hd_c6", CMAR, 0);
    cpu_req = 1'b0;
    step("hd_c7", CWT, 0);
    step("hd_c8", CRD, 0);
    step("hd_c9", CDN, 0);
    step("hd_c10", IDL, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
